// File: rtl/pattern_writer_2bit_if.sv
// Bus bundle for pattern_writer_2bit: write strobe/data/clear in, slots and status out.
`timescale 1ns/1ps
interface pattern_writer_2bit_if;
  logic       wr_en;
  logic [1:0] wr_data;
  logic       clr;
  logic [1:0] slot0, slot1, slot2, slot3, slot4, slot5, slot6, slot7;
  logic [2:0] wr_ptr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       wr_ack;
  logic       overflow;

  modport master (
    output wr_en, wr_data, clr,
    input  slot0, slot1, slot2, slot3, slot4, slot5, slot6, slot7,
    input  wr_ptr, count, full, empty, wr_ack, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr,
    output slot0, slot1, slot2, slot3, slot4, slot5, slot6, slot7,
    output wr_ptr, count, full, empty, wr_ack, overflow
  );
endinterface

// File: rtl/pattern_writer_2bit.sv
// Eight-slot 2-bit pattern store with EMPTY/FILLING/FULL tracking.
// wr_ptr uses read-select encoding: value p addresses slot (p-1) mod 8.
`timescale 1ns/1ps
module pattern_writer_2bit #(
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pattern_writer_2bit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] slot_q [8];
  logic [1:0] slot_d [8];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] count_q, count_d;
  logic       wr_ack_q, wr_ack_d;
  logic       overflow_q, overflow_d;
  logic       accept;
  logic [2:0] wr_idx;

  // Physical slot addressed by the read-select style pointer.
  assign wr_idx = wr_ptr_q - 3'd1;

  // Next-state: clear wins over write; full-store policy chosen by OVERWRITE.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wr_ack_d   = 1'b0;
    overflow_d = 1'b0;
    accept     = 1'b0;

    if (bus.clr) begin
      state_d  = ST_EMPTY;
      slot_d   = '{default: '0};
      wr_ptr_d = 3'd1;
      count_d  = '0;
    end else if (bus.wr_en) begin
      case (state_q)
        ST_EMPTY: begin
          accept  = 1'b1;
          state_d = ST_FILLING;
          count_d = 4'd1;
        end
        ST_FILLING: begin
          accept  = 1'b1;
          count_d = count_q + 4'd1;
          if (count_q == 4'd7) begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (OVERWRITE) begin
            accept = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase

      if (accept) begin
        slot_d[wr_idx] = bus.wr_data;
        wr_ptr_d       = wr_ptr_q + 3'd1;
        wr_ack_d       = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      slot_q     <= '{default: '0};
      wr_ptr_q   <= 3'd1;
      count_q    <= '0;
      wr_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wr_ack_q   <= wr_ack_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.slot0    = slot_q[0];
  assign bus.slot1    = slot_q[1];
  assign bus.slot2    = slot_q[2];
  assign bus.slot3    = slot_q[3];
  assign bus.slot4    = slot_q[4];
  assign bus.slot5    = slot_q[5];
  assign bus.slot6    = slot_q[6];
  assign bus.slot7    = slot_q[7];
  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.count    = count_q;
  assign bus.full     = (state_q == ST_FULL);
  assign bus.empty    = (state_q == ST_EMPTY);
  assign bus.wr_ack   = wr_ack_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pattern_writer_2bit.sv
// Bench for pattern_writer_2bit: drives one drop-policy and one overwrite-policy
// instance with identical stimulus and compares both against a slot-array model.
`timescale 1ns/1ps
module tb_pattern_writer_2bit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pattern_writer_2bit_if if0 ();
  pattern_writer_2bit_if if1 ();

  pattern_writer_2bit #(.OVERWRITE(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pattern_writer_2bit #(.OVERWRITE(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered per instance (index 0 = drop, 1 = overwrite).
  logic [15:0] obs_slots [2];
  logic [2:0]  obs_ptr   [2];
  logic [3:0]  obs_cnt   [2];
  logic [3:0]  obs_flags [2];

  assign obs_slots[0] = {if0.slot7, if0.slot6, if0.slot5, if0.slot4,
                         if0.slot3, if0.slot2, if0.slot1, if0.slot0};
  assign obs_slots[1] = {if1.slot7, if1.slot6, if1.slot5, if1.slot4,
                         if1.slot3, if1.slot2, if1.slot1, if1.slot0};
  assign obs_ptr[0]   = if0.wr_ptr;
  assign obs_ptr[1]   = if1.wr_ptr;
  assign obs_cnt[0]   = if0.count;
  assign obs_cnt[1]   = if1.count;
  assign obs_flags[0] = {if0.full, if0.empty, if0.wr_ack, if0.overflow};
  assign obs_flags[1] = {if1.full, if1.empty, if1.wr_ack, if1.overflow};

  // Reference model: slot contents, index of next physical slot, number stored.
  int m_slot [2][8];
  int m_next [2];
  int m_cnt  [2];
  bit m_ack  [2];
  bit m_ovf  [2];
  bit acc    [2];
  int acc_sel[2];
  int acc_val[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_slot[k][i] = 0;
      m_next[k] = 0;
      m_cnt[k]  = 0;
      m_ack[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
      acc[k]    = 1'b0;
    end
  endtask

  task automatic model_update(input bit en, input int d, input bit c);
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (c) begin
        for (int i = 0; i < 8; i++) m_slot[k][i] = 0;
        m_next[k] = 0;
        m_cnt[k]  = 0;
        m_ack[k]  = 1'b0;
        m_ovf[k]  = 1'b0;
      end else if (en) begin
        if (m_cnt[k] < 8 || k == 1) begin
          acc[k]     = 1'b1;
          acc_sel[k] = (m_next[k] + 1) % 8;
          acc_val[k] = d;
          m_slot[k][m_next[k]] = d;
          m_next[k] = (m_next[k] + 1) % 8;
          if (m_cnt[k] < 8) m_cnt[k]++;
          m_ack[k] = 1'b1;
          m_ovf[k] = 1'b0;
        end else begin
          m_ack[k] = 1'b0;
          m_ovf[k] = 1'b1;
        end
      end else begin
        m_ack[k] = 1'b0;
        m_ovf[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string where);
    logic [3:0] exp_flags;
    int idx;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("%s.d%0d.slot%0d", where, k, i),
            8'(obs_slots[k][2*i +: 2]), 8'(m_slot[k][i]));
      chk($sformatf("%s.d%0d.wr_ptr", where, k), 8'(obs_ptr[k]), 8'((m_next[k] + 1) % 8));
      chk($sformatf("%s.d%0d.count", where, k), 8'(obs_cnt[k]), 8'(m_cnt[k]));
      exp_flags = {m_cnt[k] == 8, m_cnt[k] == 0, m_ack[k], m_ovf[k]};
      chk($sformatf("%s.d%0d.flags", where, k), 8'(obs_flags[k]), 8'(exp_flags));
      if (acc[k]) begin
        // Read mux at the select value used for the write returns that write.
        idx = (acc_sel[k] + 7) % 8;
        chk($sformatf("%s.d%0d.rdmux", where, k), 8'(obs_slots[k][2*idx +: 2]), 8'(acc_val[k]));
      end
    end
  endtask

  task automatic step(input bit en, input logic [1:0] d, input bit c, input string where);
    if0.wr_en = en; if0.wr_data = d; if0.clr = c;
    if1.wr_en = en; if1.wr_data = d; if1.clr = c;
    @(posedge clk);
    if (rst_n) model_update(en, int'(d), c);
    #1;
    check_all(where);
  endtask

  initial begin
    logic [1:0] pat [8];
    bit         r_en;
    bit         r_clr;
    logic [1:0] r_d;
    pat = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    total = 0;
    bad   = 0;

    rst_n = 1'b0;
    if0.wr_en = 1'b0; if0.wr_data = '0; if0.clr = 1'b0;
    if1.wr_en = 1'b0; if1.wr_data = '0; if1.clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, "idle0");

    // Fill sequence 0,1,2,3,0,1,2,3 into slot0..slot7.
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, $sformatf("fill%0d", i));
    step(1'b0, 2'd0, 1'b0, "full_idle");

    // Writes while full: drop instance overflows, overwrite instance replaces oldest.
    step(1'b1, 2'd3, 1'b0, "fullwr0");
    step(1'b0, 2'd0, 1'b0, "fullwr_gap");
    step(1'b1, 2'd3, 1'b0, "fullwr1");
    step(1'b1, 2'd3, 1'b0, "fullwr2");
    step(1'b0, 2'd0, 1'b0, "fullwr_idle");

    // Clear, three writes, then clear together with a write.
    step(1'b0, 2'd0, 1'b1, "clr0");
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i + 1), 1'b0, $sformatf("pre_clr%0d", i));
    step(1'b1, 2'd3, 1'b1, "clr_wr");
    step(1'b0, 2'd0, 1'b0, "clr_idle");

    // Five writes, then asynchronous reset between edges.
    for (int i = 0; i < 5; i++) step(1'b1, 2'(3 - (i % 4)), 1'b0, $sformatf("pre_rst%0d", i));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    step(1'b1, 2'd1, 1'b0, "wr_in_rst");
    rst_n = 1'b1;
    step(1'b1, 2'd2, 1'b0, "post_rst_wr");
    step(1'b0, 2'd0, 1'b0, "post_rst_idle");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r_en  = ($urandom_range(0, 9) < 7);
      r_clr = ($urandom_range(0, 24) == 0);
      r_d   = 2'($urandom_range(0, 3));
      step(r_en, r_d, r_clr, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_writer_2bit.md
PATTERN_WRITER_2BIT -- requirements
Module: pattern_writer_2bit

Interface
REQ-001 Parameter: OVERWRITE, default 0, selects full-store behaviour (0 = drop new writes, 1 = overwrite the oldest slot).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_en  input  1  write strobe; each cycle it is high is one write request.
REQ-006 wr_data  input  2  2-bit pattern value to store.
REQ-007 clr  input  1  synchronous clear of pointer, count and all slots.
REQ-008 slot0..slot7  output  2 each  stored pattern values, registered; feed an 8:1 2-bit read mux.
REQ-009 wr_ptr  output  3  next write index, in read-select encoding: value 0 addresses slot7, value k (1..7) addresses slot(k-1).
REQ-010 count  output  4  number of valid slots, 0..8.
REQ-011 full  output  1  high when count == 8.
REQ-012 empty  output  1  high when count == 0.
REQ-013 wr_ack  output  1  one-cycle pulse, the cycle after a write is accepted.
REQ-014 overflow  output  1  one-cycle pulse, the cycle after a write is rejected while full (OVERWRITE=0 only).

Function
REQ-015 The FSM SHALL have three states: EMPTY, FILLING, FULL; full/empty SHALL decode from state.
REQ-016 Accepted write: the slot addressed by wr_ptr SHALL take wr_data at the clock edge.
REQ-017 Each accepted write SHALL advance wr_ptr 1->2->...->7->0->1 (mod-8 increment).
REQ-018 Fill order from reset SHALL therefore be slot0, slot1, ..., slot6, slot7.
REQ-019 EMPTY + write -> FILLING, count=1.
REQ-020 FILLING + write with count==7 -> FULL, count=8.
REQ-021 FILLING + write with count<7 -> FILLING, count+1.
REQ-022 FULL + write with OVERWRITE=0: slots, wr_ptr and count SHALL be unchanged, and overflow SHALL pulse next cycle with no wr_ack.
REQ-023 FULL + write with OVERWRITE=1: wr_ptr slot (the oldest) SHALL be written, wr_ptr SHALL advance, count SHALL stay 8, and wr_ack SHALL pulse.
REQ-024 clr SHALL, at the clock edge, set all slots to 2'b00, wr_ptr to 3'b001, count to 0, state to EMPTY, and wr_ack/overflow to 0.
REQ-025 clr and wr_en in the same cycle: clr SHALL win and the write SHALL be discarded without ack.
REQ-026 No write (wr_en low) SHALL change any state; wr_ack and overflow SHALL return to 0.
REQ-027 Write latency: the slot value, wr_ptr, count and full SHALL all update at the same edge that samples wr_en.
REQ-028 wr_data SHALL be stored unmodified; no X shall propagate from unwritten slots (reset value defined).

Reset
REQ-029 rst_n low SHALL immediately force slot0..7=2'b00, wr_ptr=3'b001, count=0, state EMPTY, empty=1, full=0, wr_ack=0, overflow=0.
REQ-030 Reset asserted mid-fill SHALL discard all stored data; the first write after release SHALL go to slot0.
REQ-031 Reset release SHALL take effect on the first rising edge after rst_n goes high; no write is accepted while rst_n is low.

Verification
REQ-032 Reset, then 8 writes 0,1,2,3,0,1,2,3 -> slot0..7 = 0,1,2,3,0,1,2,3; wr_ptr=1; count=8; full=1; 8 wr_ack pulses.
REQ-033 OVERWRITE=0, full, write 2'b11 -> slots unchanged, overflow pulses once, no wr_ack, count=8.
REQ-034 OVERWRITE=1, full (wr_ptr=1), two writes 3,3 -> slot0=3, slot1=3, wr_ptr=3, count=8.
REQ-035 3 writes, then clr with wr_en=1 -> all slots 0, count=0, empty=1, wr_ptr=1, no wr_ack.
REQ-036 5 writes, rst_n low asynchronously between edges -> outputs reset before the next edge; the next write lands in slot0.
REQ-037 Cross-check: for each wr_ptr value p, a read mux with sel=p SHALL return the value just written at p.
